dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RSA CPU: the memory end of the Memory-stage interface.
- The CPU presents a word address, write data and a write strobe; this block accepts the request, inserts a programmable number of wait states, and performs the read or write.
- It then returns a one-cycle response and holds the pipeline stalled until that response is ready.
- It sits between the Memory-stage pipeline register and the data RAM, replacing a purely combinational memory.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15)

Ports:
- clk  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req_valid  in  1  CPU presents a memory request
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; bits [1:0] must be 0
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid; one-cycle pulse
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  request was misaligned or out of range
- stall  out  1  CPU must hold its Fetch through Memory stages

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid = 1, latch req_we, req_addr and req_wdata, and compute err.
  - err = (req_addr[1:0] != 0) | (req_addr[31:ADDR_WIDTH+2] != 0).
  - If err or WAIT_STATES = 0, go to RESP; otherwise load wait_cnt = WAIT_STATES-1 and go to WAIT.
- WAIT:
  - req_ready = 0. If wait_cnt = 0, go to RESP; else decrement wait_cnt.
  - On the WAIT to RESP edge: a write commits mem[addr[ADDR_WIDTH+1:2]]; a read captures that word into rsp_rdata.
- IDLE to RESP with no error (WAIT_STATES = 0): the commit or capture happens on that same edge.
- RESP:
  - rsp_valid = 1 and req_ready = 0.
  - rsp_err reflects the latched err.
  - Unconditionally return to IDLE next cycle.
- Error requests:
  - Never touch the RAM.
  - Load rsp_rdata = 0 and skip WAIT.
- Writes load rsp_rdata = 0.
- rsp_rdata and rsp_err hold their values after RESP until the next response loads them.
- stall = (state == IDLE & req_valid) | (state == WAIT). It is 0 in RESP, so the CPU advances on the RESP edge.
- req_valid arriving during WAIT or RESP is ignored; the CPU re-presents it in the following IDLE cycle.
- A read of an address returns the last value written to it. Contents are undefined until first written.

## Timing
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait_cnt = 0, stall = req_valid (combinational). RAM contents are not reset.
- Latency: the response is WAIT_STATES+1 cycles after the acceptance edge (the IDLE cycle with req_valid = 1). An error response is always 1 cycle after acceptance.
- Throughput: one request per WAIT_STATES+2 cycles; back-to-back requests return through IDLE.
- stall, req_ready and rsp_valid are combinational decodes of state and req_valid only. There is no path from req_addr or req_wdata to any output.
- Reset asserted mid-operation: return to IDLE asynchronously; no rsp_valid is produced.
  - A write still in WAIT is discarded.
  - A write already committed stays.
- Simultaneous reset release and req_valid: the request is accepted on the first clock edge after release.

## Structure
- Package dmem_pkg holds:
  - state enum dmem_state_t {IDLE, WAIT, RESP}
  - WORD_BYTES = 4
  - the wait_cnt width constant WAIT_CNT_W = 4
- Sub-module dmem_array: single-port synchronous RAM with clk, we, addr[ADDR_WIDTH-1:0], wdata, and registered rdata.
  - It has no reset.
  - The top FSM drives its enable and captures its output into rsp_rdata.

## Test plan
- Write then read, WAIT_STATES = 1: write 0xDEADBEEF to 0x10, then read 0x10 → rsp_valid 2 cycles after each acceptance, rdata = 0xDEADBEEF, err = 0; stall high for exactly 2 cycles per request.
- WAIT_STATES = 0: read 0x0 after writing 0x12345678 → rsp_valid 1 cycle after acceptance with rdata = 0x12345678; stall high for 1 cycle.
- Misaligned write to 0x13 → rsp_err = 1, rdata = 0, response after 1 cycle; a later read of 0x10 still returns the prior value.
- Out-of-range read of 0x1000 with ADDR_WIDTH = 10 → rsp_err = 1, rdata = 0, RAM untouched.
- Reset pulsed during WAIT of a write of 0xAAAA5555 to 0x20 (WAIT_STATES = 3) → no rsp_valid; all outputs return to reset values; a subsequent read of 0x20 does not return 0xAAAA5555.
- req_valid held high continuously with alternating addresses → each request is served exactly once, with req_ready low during WAIT and RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder that sits at the
// Memory stage of the pipelined RSA CPU.
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES   : bytes per RAM word (byte address -> word index)
//   BYTE_OFF_W   : number of byte-offset bits dropped from a byte address
//   WAIT_CNT_W   : width of the wait-state down-counter (0..15 wait states)
//   addr_err()   : misalignment / out-of-range test for a request address
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_OFF_W = $clog2(WORD_BYTES);
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // A request is bad if it is not word aligned or if any byte-address bit
   // above the RAM's word-index field is set. A shift of 32 or more clears
   // the vector, so a RAM spanning the whole address space never flags range.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input int unsigned addr_width);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[BYTE_OFF_W-1:0] != '0);
      out_of_range = ((addr >> (addr_width + BYTE_OFF_W)) != 32'd0);
      return misaligned | out_of_range;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous data RAM, 2**ADDR_WIDTH words of 32 bits, with a
// registered read port. No reset: contents and the read register are
// undefined until written / first read.
//   clk   in  : clock
//   en    in  : access enable; nothing happens when low
//   we    in  : 1 = write wdata to addr, 0 = load mem[addr] into rdata
//   addr  in  : word index
//   wdata in  : write data
//   rdata out : registered read data (updates only on an enabled read)
// -----------------------------------------------------------------------------
module dmem_array #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // Write-or-read per access; the read register holds between reads so the
   // responder can sample it during its response cycle.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata_q <= mem[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory end of the CPU's Memory-stage interface. Accepts one request at a
// time, waits WAIT_STATES cycles, performs the RAM read or write and returns
// a one-cycle response while keeping the pipeline stalled until then.
//
// Parameters
//   ADDR_WIDTH  : word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words
//   WAIT_STATES : extra cycles between acceptance and response (0..15)
//
// Ports
//   clk       in  : sole clock, rising edge
//   reset     in  : asynchronous, active-low reset
//   req_valid in  : CPU presents a request
//   req_ready out : responder idle, request accepted this cycle if valid
//   req_we    in  : 1 = write, 0 = read
//   req_addr  in  : byte address, must be word aligned and in range
//   req_wdata in  : write data
//   rsp_valid out : one-cycle response pulse
//   rsp_rdata out : read data (0 for writes and errors), held until next rsp
//   rsp_err   out : request was misaligned or out of range, held likewise
//   stall     out : CPU holds its Fetch..Memory stages
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall
);

   localparam bit NO_WAIT = (WAIT_STATES == 0);
   // Counter preload; the WAIT state is only entered when WAIT_STATES > 0.
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      NO_WAIT ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

   // ---------------------------------------------------------------- state
   dmem_state_t           state_q,     state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
   logic                  we_q,        we_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [31:0]           wdata_q,     wdata_d;
   logic                  err_q,       err_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q,   rsp_err_d;

   // ------------------------------------------------------- RAM interface
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;

   logic                  req_err;
   logic                  in_idle;
   logic                  in_wait;
   logic                  in_resp;
   logic [31:0]           rsp_rdata_now;

   assign req_err = addr_err(req_addr, ADDR_WIDTH);
   assign in_idle = (state_q == IDLE);
   assign in_wait = (state_q == WAIT);
   assign in_resp = (state_q == RESP);

   // The RAM access happens on the edge that enters RESP without error:
   // either straight from IDLE (no wait states) or at the end of WAIT.
   // Gating with reset keeps a request presented while held in reset from
   // touching the RAM.
   always_comb begin
      ram_en = 1'b0;
      if (reset) begin
         if (in_idle) begin
            ram_en = req_valid & ~req_err & NO_WAIT;
         end else if (in_wait) begin
            ram_en = (wait_cnt_q == '0);
         end
      end
   end

   // From IDLE the request comes straight off the ports; from WAIT it comes
   // from the latched copy.
   always_comb begin
      if (in_idle) begin
         ram_we    = req_we;
         ram_addr  = req_addr[ADDR_WIDTH+BYTE_OFF_W-1:BYTE_OFF_W];
         ram_wdata = req_wdata;
      end else begin
         ram_we    = we_q;
         ram_addr  = addr_q;
         ram_wdata = wdata_q;
      end
   end

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Response data for the current RESP cycle. The RAM read register was
   // loaded on the edge that entered RESP, so it is valid throughout RESP.
   assign rsp_rdata_now = (we_q | err_q) ? 32'd0 : ram_rdata;

   // ------------------------------------------------------ next-state logic
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr[ADDR_WIDTH+BYTE_OFF_W-1:BYTE_OFF_W];
               wdata_d = req_wdata;
               err_d   = req_err;
               // Errors never wait: they skip the RAM entirely.
               if (req_err || NO_WAIT) begin
                  state_d = RESP;
               end else begin
                  wait_cnt_d = WAIT_LOAD;
                  state_d    = WAIT;
               end
            end
         end

         WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = RESP;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end

         RESP: begin
            // Keep the response values visible after the pulse ends.
            rsp_rdata_d = rsp_rdata_now;
            rsp_err_d   = err_q;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // --------------------------------------------------------------- outputs
   // Handshake outputs decode only state and req_valid.
   assign req_ready = in_idle;
   assign rsp_valid = in_resp;
   assign stall     = (in_idle & req_valid) | in_wait;

   // During RESP show the fresh response; otherwise the held copy.
   assign rsp_rdata = in_resp ? rsp_rdata_now : rsp_rdata_q;
   assign rsp_err   = in_resp ? err_q         : rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders (WAIT_STATES = 1, 0, 3) share one clock. A driver issues
// directed and random requests; each accepted request pushes its expected
// response (cycle, data, error) from a behavioural memory model into a
// per-instance queue, and a monitor pops and compares on every rsp_valid.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int NI = 3;
   localparam int AW = 10;

   typedef struct packed {
      int unsigned cyc;
      logic [31:0] rdata;
      logic        err;
      logic        chk;    // 0 when the read targets a never-written word
   } exp_t;

   logic              clk = 1'b0;
   logic [NI-1:0]     rst_n;
   logic [NI-1:0]     req_valid;
   logic [NI-1:0]     req_ready;
   logic [NI-1:0]     req_we;
   logic [NI-1:0]     rsp_valid;
   logic [NI-1:0]     rsp_err;
   logic [NI-1:0]     stall;
   logic [31:0]       req_addr  [NI];
   logic [31:0]       req_wdata [NI];
   logic [31:0]       rsp_rdata [NI];

   int                cyc = 0;
   int                n_cmp = 0;
   int                n_bad = 0;

   exp_t              sb0[$];
   exp_t              sb1[$];
   exp_t              sb2[$];
   exp_t              hold_e   [NI];
   bit                hold_pend[NI];
   logic [31:0]       mdl[int];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      dmem_responder #(
         .ADDR_WIDTH  (AW),
         .WAIT_STATES (gi == 0 ? 1 : (gi == 1 ? 0 : 3))
      ) u_dut (
         .clk       (clk),
         .reset     (rst_n[gi]),
         .req_valid (req_valid[gi]),
         .req_ready (req_ready[gi]),
         .req_we    (req_we[gi]),
         .req_addr  (req_addr[gi]),
         .req_wdata (req_wdata[gi]),
         .rsp_valid (rsp_valid[gi]),
         .rsp_rdata (rsp_rdata[gi]),
         .rsp_err   (rsp_err[gi]),
         .stall     (stall[gi])
      );
   end

   function automatic int ws_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   // ------------------------------------------------------------ checking
   task automatic chk(input string name, input int k,
                      input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s dut%0d: got 0x%08h, want 0x%08h (t=%0t)",
                  name, k, act, want, $time);
      end
   endtask

   task automatic fail_now(input string name, input int k, input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s dut%0d: %s (t=%0t)", name, k, what, $time);
   endtask

   function automatic void push_exp(input int k, input exp_t e);
      case (k)
         0:       sb0.push_back(e);
         1:       sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endfunction

   function automatic int sb_size(input int k);
      case (k)
         0:       return sb0.size();
         1:       return sb1.size();
         default: return sb2.size();
      endcase
   endfunction

   function automatic exp_t pop_exp(input int k);
      case (k)
         0:       return sb0.pop_front();
         1:       return sb1.pop_front();
         default: return sb2.pop_front();
      endcase
   endfunction

   // Reference model: a word-addressed memory per instance. Bad addresses
   // answer after one cycle with zero data; good ones after WAIT_STATES+1.
   function automatic exp_t model(input int k, input bit we,
                                  input logic [31:0] addr,
                                  input logic [31:0] wd, input int c);
      exp_t e;
      bit   bad;
      int   key;
      bad     = ((addr % 4) != 0) || (addr >= 32'(4 * (1 << AW)));
      e.err   = bad;
      e.rdata = 32'd0;
      e.chk   = 1'b1;
      e.cyc   = int'(c + (bad ? 1 : ws_of(k) + 1));
      if (!bad) begin
         key = k * (1 << AW) + int'(addr / 4);
         if (we) begin
            mdl[key] = wd;
         end else if (mdl.exists(key)) begin
            e.rdata = mdl[key];
         end else begin
            e.chk = 1'b0;
         end
      end
      return e;
   endfunction

   // Monitor: compare every response against the head of its queue, then
   // check that data/err are still held the cycle after the pulse.
   initial begin
      exp_t e;
      for (int k = 0; k < NI; k++) hold_pend[k] = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         for (int k = 0; k < NI; k++) begin
            if (!rst_n[k]) begin
               hold_pend[k] = 1'b0;
            end else if (rsp_valid[k]) begin
               chk("ready_in_resp", k, 32'(req_ready[k]), 32'd0);
               if (sb_size(k) == 0) begin
                  fail_now("unexpected_rsp", k, "got rsp_valid, want no response");
                  hold_pend[k] = 1'b0;
               end else begin
                  e = pop_exp(k);
                  chk("rsp_cycle", k, 32'(cyc), 32'(e.cyc));
                  chk("rsp_err", k, 32'(rsp_err[k]), 32'(e.err));
                  if (e.chk) chk("rsp_rdata", k, rsp_rdata[k], e.rdata);
                  $display("dut%0d rsp cyc=%0d rdata=0x%08h err=%0b",
                           k, cyc, rsp_rdata[k], rsp_err[k]);
                  hold_e[k]    = e;
                  hold_pend[k] = 1'b1;
               end
            end else if (hold_pend[k]) begin
               chk("hold_err", k, 32'(rsp_err[k]), 32'(hold_e[k].err));
               if (hold_e[k].chk) chk("hold_rdata", k, rsp_rdata[k], hold_e[k].rdata);
               hold_pend[k] = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   // Called at a falling edge; returns at a falling edge with the DUT idle.
   task automatic do_req(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd);
      int   n;
      int   st;
      int   lat;
      exp_t e;
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wd;
      #1;
      n = 0;
      while (!req_ready[k] && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready[k]) begin
         fail_now("ready_timeout", k, "req_ready stayed 0, want 1 within 50 cycles");
         req_valid[k] = 1'b0;
         return;
      end
      e   = model(k, we, addr, wd, cyc);
      push_exp(k, e);
      lat = int'(e.cyc) - cyc;
      st  = stall[k] ? 1 : 0;
      @(negedge clk);
      req_valid[k] = 1'b0;
      req_addr[k]  = $urandom;
      req_wdata[k] = $urandom;
      #1;
      n = 0;
      while (!rsp_valid[k] && n < 50) begin
         if (stall[k]) st++;
         @(negedge clk);
         #1;
         n++;
      end
      if (!rsp_valid[k]) begin
         fail_now("rsp_timeout", k, "no rsp_valid, want one within 50 cycles");
      end else begin
         chk("stall_cycles", k, 32'(st), 32'(lat));
         chk("stall_in_resp", k, 32'(stall[k]), 32'd0);
      end
      @(negedge clk);
   endtask

   // req_valid held high; a new request is presented after each acceptance.
   task automatic cont_test(input int k, input int n);
      int          i;
      int          guard;
      int          last;
      bit          acc;
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      exp_t        e;
      i = 0; guard = 0; last = -1;
      w = 1'b1; a = 32'h40; d = $urandom;
      req_valid[k] = 1'b1; req_we[k] = w; req_addr[k] = a; req_wdata[k] = d;
      while (i < n && guard < 400) begin
         #1;
         acc = 1'b0;
         if (req_ready[k]) begin
            e = model(k, w, a, d, cyc);
            push_exp(k, e);
            if (last >= 0) chk("accept_gap", k, 32'(cyc - last), 32'(ws_of(k) + 2));
            last = cyc;
            i++;
            acc = 1'b1;
         end
         @(negedge clk);
         guard++;
         if (i >= n) begin
            req_valid[k] = 1'b0;
         end else if (acc) begin
            w = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            a = (i % 2 == 1) ? 32'h44 : 32'h40;
            d = $urandom;
            req_we[k] = w; req_addr[k] = a; req_wdata[k] = d;
         end
      end
      req_valid[k] = 1'b0;
      if (i < n) fail_now("cont_timeout", k, "requests not all accepted within 400 cycles");
      repeat (ws_of(k) + 3) @(negedge clk);
   endtask

   task automatic rand_test(input int k, input int n);
      int          r;
      logic [31:0] a;
      for (int j = 0; j < n; j++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
         end else if (r == 1) begin
            a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
         end else begin
            a = 32'h80 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         end
         do_req(k, 1'($urandom_range(0, 1)), a, $urandom);
      end
   endtask

   task automatic reset_test();
      do_req(2, 1'b1, 32'h20, 32'h1111_1111);
      do_req(2, 1'b0, 32'h20, 32'h0);
      // Start a write and kill it with reset while it is waiting.
      req_valid[2] = 1'b1; req_we[2] = 1'b1;
      req_addr[2]  = 32'h20; req_wdata[2] = 32'hAAAA_5555;
      #1;
      chk("abort_accept_ready", 2, 32'(req_ready[2]), 32'd1);
      @(negedge clk);
      req_valid[2] = 1'b0;
      #1;
      chk("abort_wait_stall", 2, 32'(stall[2]), 32'd1);
      #2;
      rst_n[2] = 1'b0;
      #1;
      chk("rst_mid_ready", 2, 32'(req_ready[2]), 32'd1);
      chk("rst_mid_rsp_valid", 2, 32'(rsp_valid[2]), 32'd0);
      chk("rst_mid_rdata", 2, rsp_rdata[2], 32'd0);
      chk("rst_mid_err", 2, 32'(rsp_err[2]), 32'd0);
      chk("rst_mid_stall", 2, 32'(stall[2]), 32'd0);
      req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h20;
      #1;
      chk("rst_stall_follows_valid", 2, 32'(stall[2]), 32'd1);
      repeat (3) @(negedge clk);
      // Release with the request already present: accepted on the next edge.
      rst_n[2] = 1'b1;
      do_req(2, 1'b0, 32'h20, 32'h0);
   endtask

   // ----------------------------------------------------------------- main
   initial begin
      rst_n     = '1;
      req_valid = '0;
      req_we    = '0;
      for (int k = 0; k < NI; k++) begin
         req_addr[k]  = '0;
         req_wdata[k] = '0;
      end
      #1;
      rst_n        = '0;
      req_valid[1] = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         chk("reset_ready", k, 32'(req_ready[k]), 32'd1);
         chk("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
         chk("reset_rdata", k, rsp_rdata[k], 32'd0);
         chk("reset_err", k, 32'(rsp_err[k]), 32'd0);
         chk("reset_stall", k, 32'(stall[k]), (k == 1) ? 32'd1 : 32'd0);
      end
      req_valid[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = '1;
      @(negedge clk);

      // Directed: WAIT_STATES = 1
      do_req(0, 1'b1, 32'h10,  32'hDEAD_BEEF);
      do_req(0, 1'b0, 32'h10,  32'h0);
      do_req(0, 1'b1, 32'h13,  32'h5555_5555);
      do_req(0, 1'b0, 32'h10,  32'h0);
      do_req(0, 1'b0, 32'h1000, 32'h0);
      do_req(0, 1'b1, 32'hFFC, 32'hCAFE_F00D);
      do_req(0, 1'b0, 32'hFFC, 32'h0);
      // Directed: WAIT_STATES = 0
      do_req(1, 1'b1, 32'h0, 32'h1234_5678);
      do_req(1, 1'b0, 32'h0, 32'h0);
      do_req(1, 1'b1, 32'h1000, 32'h7777_7777);
      do_req(1, 1'b0, 32'h0, 32'h0);
      // Reset during WAIT: WAIT_STATES = 3
      reset_test();

      for (int k = 0; k < NI; k++) cont_test(k, 8);
      for (int k = 0; k < NI; k++) rand_test(k, 30);

      repeat (6) @(negedge clk);
      for (int k = 0; k < NI; k++) chk("scoreboard_drained", k, 32'(sb_size(k)), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
